csa_accumulator: RTL

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 102 ++++++++++
 1 files changed

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: operands are folded into a redundant S/C pair at one per cycle,
// then the carry vector is rippled out iteratively before the group result is offered.
module csa_accumulator #(
  parameter int OP_W  = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [4:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] maj;
  logic [ACC_W-1:0] res_carry;

  assign x_ext     = ACC_W'(in_data);
  assign maj       = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
  assign res_carry = s_q & c_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d   = s_q ^ c_q ^ x_ext;
          c_d   = {maj[ACC_W-2:0], 1'b0};
          // The carry leaving the top bit is weight lost from S+C, so the group overflowed.
          ovf_d = ovf_q | maj[ACC_W-1];
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (c_q != '0) begin
          s_d   = s_q ^ c_q;
          c_d   = {res_carry[ACC_W-2:0], 1'b0};
          ovf_d = ovf_q | res_carry[ACC_W-1];
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshakes and result gating come straight from the registered state.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? s_q   : '0;
  assign out_count = out_valid ? cnt_q : '0;
  assign out_ovf   = out_valid ? ovf_q : 1'b0;

endmodule
